pe_start_token_fifo: RTL and testbench



---
 rtl/pe_start_token_fifo_pkg.sv | 17 +
 rtl/pe_start_token_fifo_if.sv | 31 +++
 rtl/pe_start_token_srl.sv | 31 +++
 rtl/pe_start_token_fifo.sv | 88 ++++++++
 tb/tb_pe_start_token_fifo.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pe_start_token_fifo_pkg.sv
// Shared configuration for the PE start-token FIFO: default geometry and the
// geometry sanity check used at elaboration.
package pe_start_token_fifo_pkg;

  localparam int PE_START_FIFO_DEPTH = 14;
  localparam int PE_START_FIFO_AW    = 4;

  // The SRL read address must reach every slot, and a one-slot FIFO cannot
  // sustain a push and a pop in the same cycle.
  function automatic bit pe_start_fifo_cfg_ok(input int aw, input int depth);
    return (depth >= 2) && ((1 << aw) >= depth);
  endfunction

  localparam bit PE_START_FIFO_CFG_OK =
    pe_start_fifo_cfg_ok(PE_START_FIFO_AW, PE_START_FIFO_DEPTH);

endpackage

// File: rtl/pe_start_token_fifo_if.sv
// Handshake bundle between the upstream dataflow process (master) and the
// start-token FIFO (slave).
interface pe_start_token_fifo_if
  import pe_start_token_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = PE_START_FIFO_AW
);

  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_write;
  logic                  if_write_ce;
  logic                  if_full_n;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_read;
  logic                  if_read_ce;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic [ADDR_WIDTH:0]   if_fifo_cap;

  modport master (
    output if_din, if_write, if_write_ce, if_read, if_read_ce,
    input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
  );

  modport slave (
    input  if_din, if_write, if_write_ce, if_read, if_read_ce,
    output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
  );

endinterface

// File: rtl/pe_start_token_srl.sv
// Push-enabled shift array: new data enters slot 0, older entries move up one
// slot; any slot is read asynchronously by address.
module pe_start_token_srl
  import pe_start_token_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = PE_START_FIFO_AW,
  parameter int DEPTH      = PE_START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage carries no reset: contents are only observed through a gated read.
  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_dout = (32'(i_addr) < DEPTH) ? r_mem[i_addr] : '0;

endmodule

// File: rtl/pe_start_token_fifo.sv
// Start-token FIFO for the PE start handshake: show-ahead SRL queue with
// registered occupancy, read pointer and full/empty flags.
module pe_start_token_fifo
  import pe_start_token_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = PE_START_FIFO_AW,
  parameter int DEPTH      = PE_START_FIFO_DEPTH
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  pe_start_token_fifo_if.slave        s_if
);

  if (!pe_start_fifo_cfg_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_cfg
    $error("pe_start_token_fifo: need DEPTH >= 2 and 2**ADDR_WIDTH >= DEPTH");
  end

  localparam logic [ADDR_WIDTH:0] CNT_CAP = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  r_empty_n;
  logic                  r_full_n;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_srl_dout;

  // Handshakes qualify on the registered flags, so requests against a full or
  // empty queue simply vanish.
  assign w_push = s_if.if_write & s_if.if_write_ce & r_full_n;
  assign w_pop  = s_if.if_read  & s_if.if_read_ce  & r_empty_n;

  // addr tracks count-1 but saturates at 0; a simultaneous push/pop leaves it
  // alone because the shift slides the next-oldest entry into the head slot.
  always_comb begin
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    case ({w_push, w_pop})
      2'b10: begin
        w_count_nxt = r_count + CNT_ONE;
        if (r_count != '0) w_addr_nxt = r_addr + 1'b1;
      end
      2'b01: begin
        w_count_nxt = r_count - CNT_ONE;
        if (r_count != CNT_ONE) w_addr_nxt = r_addr - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_count   <= '0;
      r_addr    <= '0;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
    end else begin
      r_count   <= w_count_nxt;
      r_addr    <= w_addr_nxt;
      r_empty_n <= (w_count_nxt != '0);
      r_full_n  <= (w_count_nxt != CNT_CAP);
    end
  end

  pe_start_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk    (ap_clk),
    .i_shift(w_push),
    .i_din  (s_if.if_din),
    .i_addr (r_addr),
    .o_dout (w_srl_dout)
  );

  // Head data is forced to zero while empty so stale SRL contents never leak.
  assign s_if.if_dout             = r_empty_n ? w_srl_dout : '0;
  assign s_if.if_empty_n          = r_empty_n;
  assign s_if.if_full_n           = r_full_n;
  assign s_if.if_num_data_valid   = r_count;
  assign s_if.if_fifo_cap         = CNT_CAP;

endmodule

// File: tb/tb_pe_start_token_fifo.sv
// Bench for pe_start_token_fifo: directed vector table, hand sequences for
// full/empty/reset corners, and a long random run against a queue model.
module tb_pe_start_token_fifo;

  localparam int DW    = 1;
  localparam int AW    = 4;
  localparam int DEPTH = 14;

  logic clk;
  logic rst_n;

  pe_start_token_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

  pe_start_token_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .s_if    (fif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit q[$];

  typedef struct {
    bit w; bit wce; bit din; bit r; bit rce;
    int exp_cnt; bit exp_empty_n; bit exp_full_n; bit exp_dout;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input bit w, input bit d, input bit wce, input bit r, input bit rce);
    fif.if_write    = w;
    fif.if_din      = d;
    fif.if_write_ce = wce;
    fif.if_read     = r;
    fif.if_read_ce  = rce;
  endtask

  // Compare every output against the queue model.
  task automatic check_model(input string tag);
    chk({tag, ".count"},   int'(fif.if_num_data_valid), q.size());
    chk({tag, ".empty_n"}, int'(fif.if_empty_n), int'(q.size() != 0));
    chk({tag, ".full_n"},  int'(fif.if_full_n),  int'(q.size() != DEPTH));
    chk({tag, ".dout"},    int'(fif.if_dout),    (q.size() != 0) ? int'(q[0]) : 0);
    chk({tag, ".cap"},     int'(fif.if_fifo_cap), DEPTH);
  endtask

  // One clock with the given requests, model updated from the pre-edge state.
  task automatic cycle(input string tag, input bit w, input bit d, input bit wce,
                       input bit r, input bit rce);
    bit m_push, m_pop;
    drive(w, d, wce, r, rce);
    m_pop  = r && rce && (q.size() > 0);
    m_push = w && wce && (q.size() < DEPTH);
    @(posedge clk);
    if (m_pop)  void'(q.pop_front());
    if (m_push) q.push_back(d);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    // First cycle after release stays idle.
    @(posedge clk);
    #1;
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{1,1,1,0,0, 1,1,1,1};
    vt[1] = '{1,1,0,0,0, 2,1,1,1};
    vt[2] = '{1,1,1,0,0, 3,1,1,1};
    vt[3] = '{1,0,0,0,0, 3,1,1,1};   // write without ce
    vt[4] = '{0,0,0,1,0, 3,1,1,1};   // read without ce
    vt[5] = '{0,0,0,1,1, 2,1,1,0};
    vt[6] = '{0,0,0,1,1, 1,1,1,1};
    vt[7] = '{0,0,0,1,1, 0,0,1,0};
    vt[8] = '{0,0,0,1,1, 0,0,1,0};   // pop on empty ignored
    vt[9] = '{0,0,0,0,0, 0,0,1,0};

    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst.empty_n", int'(fif.if_empty_n), 0);
    chk("rst.full_n",  int'(fif.if_full_n), 1);
    chk("rst.count",   int'(fif.if_num_data_valid), 0);
    chk("rst.dout",    int'(fif.if_dout), 0);
    do_reset();
    check_model("idle");

    // Directed table: push 1,0,1, ce-gated no-ops, pop three, pop on empty.
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].w, vt[i].din, vt[i].wce, vt[i].r, vt[i].rce);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.count", i),   int'(fif.if_num_data_valid), vt[i].exp_cnt);
      chk($sformatf("vec%0d.empty_n", i), int'(fif.if_empty_n), int'(vt[i].exp_empty_n));
      chk($sformatf("vec%0d.full_n", i),  int'(fif.if_full_n),  int'(vt[i].exp_full_n));
      chk($sformatf("vec%0d.dout", i),    int'(fif.if_dout),    int'(vt[i].exp_dout));
    end

    // Fill to capacity, 15th push dropped, drain all 14 in order.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, bit'(i % 3 == 0), 1, 0, 0);
    chk("full.full_n", int'(fif.if_full_n), 0);
    chk("full.count",  int'(fif.if_num_data_valid), DEPTH);
    cycle("over", 1, 1, 1, 0, 0);
    chk("over.count", int'(fif.if_num_data_valid), DEPTH);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 0, 0, 0, 1, 1);
    chk("drain.empty_n", int'(fif.if_empty_n), 0);

    // Simultaneous push/pop at occupancy 5.
    for (int i = 0; i < 5; i++) cycle("pre5", 1, bit'(i & 1), 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle("pp5", 1, bit'(i & 1), 1, 1, 1);
    chk("pp5.count", int'(fif.if_num_data_valid), 5);

    // Simultaneous push/pop when full: only the pop lands.
    for (int i = 0; i < DEPTH - 5; i++) cycle("tofull", 1, bit'(i & 1), 1, 0, 0);
    cycle("ppfull", 1, 0, 1, 1, 1);
    chk("ppfull.count", int'(fif.if_num_data_valid), DEPTH - 1);

    // Simultaneous push/pop when empty: only the push lands.
    for (int i = 0; i < DEPTH - 1; i++) cycle("toempty", 0, 0, 0, 1, 1);
    cycle("ppempty", 1, 1, 1, 1, 1);
    chk("ppempty.count", int'(fif.if_num_data_valid), 1);
    chk("ppempty.dout",  int'(fif.if_dout), 1);

    // Asynchronous reset mid-cycle with tokens queued.
    cycle("prerst", 1, 1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.empty_n", int'(fif.if_empty_n), 0);
    chk("arst.full_n",  int'(fif.if_full_n), 1);
    chk("arst.count",   int'(fif.if_num_data_valid), 0);
    chk("arst.dout",    int'(fif.if_dout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle("postrst", 1, 0, 1, 0, 0);

    // Random traffic, biased through phases of filling and draining.
    for (int i = 0; i < 10000; i++) begin
      int wbias;
      wbias = ((i / 500) % 2 == 0) ? 70 : 30;
      cycle("rnd",
            bit'($urandom_range(99) < wbias), bit'($urandom_range(1)),
            bit'($urandom_range(9) != 0),
            bit'($urandom_range(99) >= wbias), bit'($urandom_range(9) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
